sobel_core: RTL and testbench

SOBEL_CORE -- requirements
Module: sobel_core

---
 rtl/sobel_core.sv | 191 +++++++++++++++++++
 tb/tb_sobel_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_core.sv
// Streaming 3x3 Sobel edge core: one gray pixel in, one edge pixel out, one-cycle latency.
// Optional statistics outputs are compiled in when SOBEL_CORE_STATS_EN is defined.
module sobel_core #(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               sof_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH_P-1:0] thresh_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic               sof_o,
  output logic               eol_o
`ifdef SOBEL_CORE_STATS_EN
  ,
  output logic [15:0]        frame_cnt_o,
  output logic [31:0]        edge_cnt_o
`endif
);

  localparam int COL_W = $clog2(LINE_W_P);
  localparam int ROW_W = $clog2(FRAME_H_P);
  localparam int AW    = WIDTH_P + 4;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H_P - 1);
  localparam logic [AW-1:0]    PIX_MAX  = {4'b0000, {WIDTH_P{1'b1}}};

  typedef enum logic [1:0] {
    MODE_MAG = 2'b00,
    MODE_THR = 2'b01,
    MODE_GX  = 2'b10,
    MODE_GY  = 2'b11
  } mode_e;

  logic               valid_q, sof_q, eol_q;
  logic [WIDTH_P-1:0] data_q;
  logic [COL_W-1:0]   col_q, col_d, tag_col;
  logic [ROW_W-1:0]   row_q, row_d, tag_row;
  mode_e              mode_q, mode_eff;
  logic [WIDTH_P-1:0] thresh_q, thresh_eff;
  logic               accept, border;

  // win_q holds the two older window columns; column 2 is assembled from the buffers and data_i.
  logic [WIDTH_P-1:0] win_q [3][2];
  logic [WIDTH_P-1:0] win   [3][3];
  logic [WIDTH_P-1:0] lb0_q [LINE_W_P];
  logic [WIDTH_P-1:0] lb1_q [LINE_W_P];

  logic signed [AW-1:0] gx, gy;
  logic [AW-1:0]        abs_gx, abs_gy, mag_sum;
  logic [WIDTH_P-1:0]   mag_sat, result_d;

  function automatic logic signed [AW-1:0] ext(input logic [WIDTH_P-1:0] p);
    return signed'({4'b0000, p});
  endfunction

  function automatic logic [WIDTH_P-1:0] sat(input logic [AW-1:0] v);
    return (v > PIX_MAX) ? {WIDTH_P{1'b1}} : v[WIDTH_P-1:0];
  endfunction

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    tag_col    = sof_i ? '0 : col_q;
    tag_row    = sof_i ? '0 : row_q;
    mode_eff   = sof_i ? mode_e'(mode_i) : mode_q;
    thresh_eff = sof_i ? thresh_i : thresh_q;
    col_d      = tag_col + 1'b1;
    row_d      = tag_row;
    if (tag_col == COL_LAST) begin
      col_d = '0;
      row_d = (tag_row == ROW_LAST) ? '0 : tag_row + 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
    end
    win[0][2] = lb0_q[tag_col];
    win[1][2] = lb1_q[tag_col];
    win[2][2] = data_i;
  end

  always_comb begin
    gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    abs_gx  = gx[AW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy  = gy[AW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag_sum = abs_gx + abs_gy;
    // Windows touching row 0/1 or column 0/1 would mix in stale buffer data, so force them to 0.
    border  = (tag_row < ROW_W'(2)) || (tag_col < COL_W'(2));
    mag_sat = border ? '0 : sat(mag_sum);
    result_d = '0;
    if (!border) begin
      unique case (mode_eff)
        MODE_MAG: result_d = mag_sat;
        MODE_THR: result_d = (mag_sat >= thresh_eff) ? {WIDTH_P{1'b1}} : '0;
        MODE_GX:  result_d = sat(abs_gx);
        MODE_GY:  result_d = sat(abs_gy);
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= MODE_MAG;
      thresh_q <= '0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= result_d;
        sof_q   <= (tag_row == '0) && (tag_col == '0);
        eol_q   <= (tag_col == COL_LAST);
        col_q   <= col_d;
        row_q   <= row_d;
        if (sof_i) begin
          mode_q   <= mode_e'(mode_i);
          thresh_q <= thresh_i;
        end
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win[r][2];
        end
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  // NOTE: line buffers carry no reset; the border rule keeps stale entries off the output.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_q[tag_col] <= lb1_q[tag_col];
      lb1_q[tag_col] <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sof_o   = sof_q;
  assign eol_o   = eol_q;

`ifdef SOBEL_CORE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [31:0] edge_cnt_q;
  logic        hit;

  assign hit = (mag_sat >= thresh_eff);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      edge_cnt_q  <= '0;
    end else if (accept) begin
      if (sof_i) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        edge_cnt_q  <= {31'd0, hit};
      end else if (hit && (edge_cnt_q != '1)) begin
        edge_cnt_q <= edge_cnt_q + 32'd1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign edge_cnt_o  = edge_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_core.sv
// Self-checking bench for sobel_core: behavioural frame model plus directed literal checks.
// Statistics checks are included when SOBEL_CORE_STATS_EN is defined.
module tb_sobel_core;
  localparam int W  = 8;
  localparam int LW = 4;
  localparam int FH = 4;

  logic         clk_i    = 1'b0;
  logic         rst_i    = 1'b1;
  logic         valid_i  = 1'b0;
  logic         ready_o;
  logic [W-1:0] data_i   = '0;
  logic         sof_i    = 1'b0;
  logic [1:0]   mode_i   = '0;
  logic [W-1:0] thresh_i = '0;
  logic         valid_o;
  logic         ready_i  = 1'b1;
  logic [W-1:0] data_o;
  logic         sof_o;
  logic         eol_o;
`ifdef SOBEL_CORE_STATS_EN
  logic [15:0]  frame_cnt_o;
  logic [31:0]  edge_cnt_o;
`endif

  sobel_core #(.WIDTH_P(W), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .sof_i(sof_i),
    .mode_i(mode_i), .thresh_i(thresh_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .sof_o(sof_o), .eol_o(eol_o)
`ifdef SOBEL_CORE_STATS_EN
    , .frame_cnt_o(frame_cnt_o), .edge_cnt_o(edge_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int data;
    bit sof;
    bit eol;
  } out_t;

  out_t   exp_q[$];
  out_t   out_log[$];
  int     checks = 0;
  int     errors = 0;
  int     img [FH][LW];
  int     m_row = 0, m_col = 0, m_mode = 0, m_thresh = 0;
  int     m_frames = 0;
  longint m_edges = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Image-level reference: pixels stored by (row,col) tag, Sobel evaluated on the stored frame.
  task automatic model_accept();
    int r, c, gx, gy, mag, res;
    bit border;
    if (sof_i) begin
      r = 0; c = 0;
      m_mode = int'(mode_i);
      m_thresh = int'(thresh_i);
      m_frames++;
    end else begin
      r = m_row; c = m_col;
    end
    img[r][c] = int'(data_i);
    border = (r < 2) || (c < 2);
    gx = 0; gy = 0; mag = 0; res = 0;
    if (!border) begin
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
      mag = sat8(iabs(gx) + iabs(gy));
      case (m_mode)
        0: res = mag;
        1: res = (mag >= m_thresh) ? 255 : 0;
        2: res = sat8(iabs(gx));
        default: res = sat8(iabs(gy));
      endcase
    end
    if (sof_i) m_edges = (mag >= m_thresh) ? 1 : 0;
    else if ((mag >= m_thresh) && (m_edges != 64'hFFFF_FFFF)) m_edges++;
    exp_q.push_back(out_t'{res, (r == 0) && (c == 0), c == LW - 1});
    if (c == LW - 1) begin
      m_col = 0;
      m_row = (r == FH - 1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  // Compare process: samples one time unit before every rising edge.
  initial begin
    bit   stall;
    out_t prev, got;
    stall = 1'b0;
    prev  = out_t'{0, 1'b0, 1'b0};
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_i) begin
        exp_q.delete();
        m_row = 0; m_col = 0; m_mode = 0; m_thresh = 0;
        m_frames = 0; m_edges = 0;
        stall = 1'b0;
        continue;
      end
      check("ready_o", ready_o, !valid_o || ready_i);
      if (stall) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", data_o, prev.data);
        check("hold_sof", sof_o, prev.sof);
        check("hold_eol", eol_o, prev.eol);
      end
`ifdef SOBEL_CORE_STATS_EN
      check("frame_cnt", frame_cnt_o, m_frames % 65536);
      check("edge_cnt", edge_cnt_o, m_edges);
`endif
      if (valid_o && ready_i) begin
        got = out_t'{int'(data_o), sof_o, eol_o};
        out_log.push_back(got);
        if (exp_q.size() == 0) begin
          check("unexpected_output", exp_q.size(), 1);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          check("data_o", got.data, e.data);
          check("sof_o", got.sof, e.sof);
          check("eol_o", got.eol, e.eol);
        end
      end
      if (valid_i && ready_o) model_accept();
      stall = valid_o && !ready_i;
      prev  = out_t'{int'(data_o), sof_o, eol_o};
    end
  end

  // Called at a falling edge; returns at the falling edge after the pixel was accepted.
  task automatic drive(input int d, input bit s, input int m, input int t);
    bit acc;
    int n;
    valid_i  = 1'b1;
    data_i   = W'(d);
    sof_i    = s;
    mode_i   = 2'(m);
    thresh_i = W'(t);
    n = 0;
    do begin
      #4;
      acc = ready_o;
      @(negedge clk_i);
      n++;
    end while (!acc && n < 100);
    if (!acc) check("drive_timeout", n, 0);
  endtask

  task automatic send_frame(input int row_pat[LW], input int m, input int t);
    for (int i = 0; i < LW*FH; i++) drive(row_pat[i % LW], i == 0, m, t);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_i = 1'b0;
    while ((exp_q.size() != 0 || valid_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit done;
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_sof_o", sof_o, 0);
    check("rst_eol_o", eol_o, 0);
`ifdef SOBEL_CORE_STATS_EN
    check("rst_frame_cnt", frame_cnt_o, 0);
    check("rst_edge_cnt", edge_cnt_o, 0);
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Flat frame: no edges anywhere, framing flags only.
    out_log.delete();
    send_frame('{100, 100, 100, 100}, 0, 0);
    drain();
    check("flat_count", out_log.size(), 16);
    for (int i = 0; i < out_log.size(); i++) begin
      check("flat_data", out_log[i].data, 0);
      check("flat_sof", out_log[i].sof, i == 0);
      check("flat_eol", out_log[i].eol, (i % 4) == 3);
    end

    // Vertical step 0,0,200,200: gx=800 saturates to 255 in the interior.
    out_log.delete();
    send_frame('{0, 0, 200, 200}, 0, 0);
    drain();
    check("step_count", out_log.size(), 16);
    for (int i = 0; i < out_log.size(); i++)
      check("step_mag", out_log[i].data, ((i / 4) >= 2 && (i % 4) >= 2) ? 255 : 0);
    out_log.delete();
    send_frame('{0, 0, 200, 200}, 3, 0);
    drain();
    for (int i = 0; i < out_log.size(); i++) check("step_gy", out_log[i].data, 0);

    // Threshold mode: gx=40 at (2,2), inclusive compare.
    out_log.delete();
    send_frame('{0, 0, 10, 10}, 1, 50);
    drain();
    check("thr50_22", out_log[10].data, 0);
    out_log.delete();
    send_frame('{0, 0, 10, 10}, 1, 40);
    drain();
    check("thr40_22", out_log[10].data, 255);

    // Back-pressure: ready_i low for 5 cycles during the stream.
    out_log.delete();
    fork
      send_frame('{0, 0, 200, 200}, 0, 0);
      begin
        ready_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("stall_ready_o", ready_o, 0);
        d0 = int'(data_o);
        repeat (5) @(negedge clk_i);
        check("stall_data_kept", data_o, d0);
        ready_i = 1'b1;
      end
    join
    drain();
    check("stall_count", out_log.size(), 16);
    check("stall_22", out_log[10].data, 255);

    // Mid-frame sof on pixel 6 with a mode change; thresh_i ignored off sof.
    out_log.delete();
    for (int i = 0; i < 6; i++) drive(100, i == 0, 0, 77);
    for (int i = 0; i < 16; i++) drive(100, i == 0, (i == 0) ? 1 : 0, (i == 0) ? 0 : 200);
    drain();
    check("resof_count", out_log.size(), 22);
    check("resof_sof6", out_log[6].sof, 1);
    check("resof_data6", out_log[6].data, 0);
    check("resof_sof5", out_log[5].sof, 0);
    check("resof_thr_16", out_log[16].data, 255);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 7; i++) drive(50 + 20*i, i == 0, 0, 0);
    valid_i = 1'b0;
    check("pre_reset_valid", valid_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_valid_o", valid_o, 0);
    check("async_data_o", data_o, 0);
    check("async_sof_o", sof_o, 0);
    check("async_eol_o", eol_o, 0);
`ifdef SOBEL_CORE_STATS_EN
    check("async_frame_cnt", frame_cnt_o, 0);
    check("async_edge_cnt", edge_cnt_o, 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(($urandom_range(0, 1) == 1) ? 255 : 0, 1'b0, 1, 0);
    drain();
    check("post_reset_count", out_log.size(), 16);
    check("post_reset_sof", out_log[0].sof, 1);

    // Randomized traffic with gaps, back-pressure and occasional sof.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int pix;
          case ($urandom_range(0, 3))
            0:       pix = 0;
            1:       pix = 255;
            default: pix = int'($urandom_range(0, 255));
          endcase
          if ($urandom_range(0, 3) == 0) begin
            valid_i = 1'b0;
            @(negedge clk_i);
          end
          drive(pix, (i == 0) || ($urandom_range(0, 24) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end
        valid_i = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk_i);
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
